io_dma_engine: RTL and testbench
================================

IO_DMA_ENGINE -- requirements
Module: io_dma_engine

Interface
REQ-001 Parameter IN_W, default 22: width of one input sample (switches plus keys).
REQ-002 Parameter OUT_W, default 26: width of the output word (LEDs).
REQ-003 Parameter DEPTH, default 64: entries per queue; power of two, at least 2.
REQ-004 Parameter HOLD, default 1: minimum clocks each io_out value is held before the next dequeue, at least 1.
REQ-005 Ports: clock in 1, system clock; all logic on rising edge.
REQ-006 Ports: rst_n in 1, asynchronous active-low reset.
REQ-007 Ports: cmd_valid in 1, command strobe; cmd_ready out 1, always 1 (single-cycle accept).
REQ-008 Ports: cmd_instr in 32, instruction word: [28:24] opcode, [23:16] target position, [7:0] bit index, [0] immediate bit.
REQ-009 Ports: f_value in 32 (first register value) and t_value in 32 (third register value).
REQ-010 Ports: apply_btn in 1, asynchronous button; io_in in IN_W, sampled inputs.
REQ-011 Ports: io_out out OUT_W, registered output word.
REQ-012 Ports: wb_valid out 1, wb_pos out 8, wb_value out 32: registered writeback.
REQ-013 Ports: in_count out clog2(DEPTH)+1 and out_count out clog2(DEPTH)+1: queue occupancies.
REQ-014 Ports: in_ovf out 1, out_ovf out 1, rd_empty_err out 1: sticky error flags.

Function
REQ-015 apply_btn SHALL pass through a 2-flop synchroniser; each synchronised rising edge SHALL push io_in into the input FIFO.
REQ-016 Commands SHALL execute only when cmd_valid=1; the writeback SHALL appear exactly one clock after acceptance; wb_valid SHALL be a one-cycle pulse, otherwise 0.
REQ-017 Opcode 01001 SHALL pop the input FIFO; wb_value = zero-extended entry; wb_pos = instr[23:16].
REQ-018 Opcode 01010 SHALL pop the input FIFO; wb_value[0] = entry[instr[7:0]], upper bits 0; an index >= IN_W SHALL yield 0.
REQ-019 Opcode 01011 SHALL return zero-extended in_count with no pop.
REQ-020 01001/01010 on an empty input FIFO SHALL produce no writeback and SHALL set rd_empty_err.
REQ-021 Opcode 00001 SHALL push f_value[OUT_W-1:0] into the output FIFO.
REQ-022 Opcode 00010 SHALL push shadow with bit t_value set to f_value[0].
REQ-023 Opcode 00011 SHALL push shadow with bit instr[23:16] set to instr[0].
REQ-024 shadow SHALL be the most recently pushed output word, or io_out if nothing is queued.
REQ-025 For 00010/00011, a bit index >= OUT_W SHALL cause no push and SHALL set out_ovf.
REQ-026 Opcode 01100 SHALL clear all sticky flags; all other opcodes SHALL be no-ops.
REQ-027 A push to a full FIFO SHALL be dropped and SHALL set in_ovf or out_ovf; pointers SHALL wrap modulo DEPTH.
REQ-028 A simultaneous push and pop on the same FIFO SHALL both succeed, including at full; count unchanged; pop on empty follows REQ-020.
REQ-029 The output FIFO SHALL dequeue into io_out when non-empty and the hold counter has expired; the hold counter SHALL reload to HOLD on each dequeue.

Reset
REQ-030 On rst_n=0: all pointers, counts, flags, wb_*, io_out and shadow SHALL be 0; the synchroniser SHALL be 0; the hold counter SHALL be expired.
REQ-031 A reset asserted mid-operation SHALL discard queued data; the first push after release SHALL land at entry 0.

Structure
REQ-032 Opcode constants and default parameter values SHALL live in the shared package io_dma_pkg.
REQ-033 Both queues SHALL be instances of one sub-module, io_fifo (parameters WIDTH, DEPTH), with push/pop/full/empty/count.

Verification
REQ-034 Three button presses with io_in=0x15,0x2A,0x3F, then 01001 x3: wb_value 0x15,0x2A,0x3F, in order, each one clock after its command.
REQ-035 Reset, then 00011 with pos=5, bit=1, HOLD=1: io_out=0x20 two clocks after the command; a second 00011 with pos=0 gives io_out=0x21.
REQ-036 64 presses, then a 65th: in_count=64, in_ovf=1; 01100 clears in_ovf.
REQ-037 01001 with the input FIFO empty: wb_valid stays 0 and rd_empty_err=1.
REQ-038 Input FIFO full, a button edge coinciding with 01001: in_count stays 64 and in_ovf stays 0.
REQ-039 With HOLD=4, two 00001 pushes (0x1, 0x2) back to back: io_out=0x1 for exactly 4 clocks, then 0x2.

Source files
------------

// File: rtl/io_dma_pkg.sv
// Shared opcodes, default sizes and the command decode for the IO DMA engine.
package io_dma_pkg;

  localparam int IN_W_DEF  = 22;
  localparam int OUT_W_DEF = 26;
  localparam int DEPTH_DEF = 64;
  localparam int HOLD_DEF  = 1;

  typedef enum logic [4:0] {
    OP_WR_OUT = 5'b00001,
    OP_SET_T  = 5'b00010,
    OP_SET_I  = 5'b00011,
    OP_RD_IN  = 5'b01001,
    OP_RD_BIT = 5'b01010,
    OP_IN_CNT = 5'b01011,
    OP_CLR    = 5'b01100
  } op_e;

  typedef struct packed {
    logic [4:0] op;
    logic [7:0] pos;
    logic [7:0] idx;
    logic       imm;
  } cmd_t;

  // imm and idx[0] share instr[0]; which one matters depends on the opcode.
  function automatic cmd_t decode(input logic [31:0] instr);
    cmd_t c;
    c.op  = instr[28:24];
    c.pos = instr[23:16];
    c.idx = instr[7:0];
    c.imm = instr[0];
    return c;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Show-ahead circular FIFO; push into a full queue succeeds only alongside a pop.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_dma_engine.sv
// Button-sampled input queue and paced output queue driving io_out, under command control.
module io_dma_engine
  import io_dma_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int HOLD  = HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_instr,
  input  logic [31:0]              f_value,
  input  logic [31:0]              t_value,
  input  logic                     apply_btn,
  input  logic [IN_W-1:0]          io_in,
  output logic [OUT_W-1:0]         io_out,
  output logic                     wb_valid,
  output logic [7:0]               wb_pos,
  output logic [31:0]              wb_value,
  output logic [$clog2(DEPTH):0]   in_count,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     in_ovf,
  output logic                     out_ovf,
  output logic                     rd_empty_err
);

  localparam int HW = $clog2(HOLD + 1) + 1;

  cmd_t             cmd;
  logic [2:0]       btn_sync;
  logic             btn_rise;
  logic             in_full, in_empty, out_full, out_empty;
  logic [IN_W-1:0]  in_head, in_shift;
  logic [OUT_W-1:0] out_head, out_data, shadow, last_word, set_word;
  logic             rd_req, rd_ok, bit_val;
  logic             is_set, is_wr, idx_ok, set_bit;
  logic [31:0]      set_idx;
  logic             out_push, out_push_ok, deq;
  logic [HW-1:0]    hold_cnt;
  logic             unused_bits;

  assign cmd         = decode(cmd_instr);
  assign cmd_ready   = 1'b1;
  assign unused_bits = ^{cmd_instr[31:29], cmd_instr[15:8], f_value};

  // btn_sync[1:0] is the synchroniser; btn_sync[2] is the edge-detect history.
  assign btn_rise = btn_sync[1] & ~btn_sync[2];

  assign rd_req   = cmd_valid & (cmd.op == OP_RD_IN || cmd.op == OP_RD_BIT);
  assign rd_ok    = rd_req & ~in_empty;
  assign in_shift = in_head >> cmd.idx;
  assign bit_val  = ({24'b0, cmd.idx} < 32'(IN_W)) & in_shift[0];

  io_fifo #(.WIDTH(IN_W), .DEPTH(DEPTH)) u_in_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (btn_rise),
    .push_data (io_in),
    .pop       (rd_ok),
    .pop_data  (in_head),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count)
  );

  // Bit ops modify the newest word headed for io_out, not the one on display.
  assign shadow   = out_empty ? io_out : last_word;
  assign is_wr    = cmd_valid & (cmd.op == OP_WR_OUT);
  assign is_set   = cmd_valid & (cmd.op == OP_SET_T || cmd.op == OP_SET_I);
  assign set_idx  = (cmd.op == OP_SET_T) ? t_value : {24'b0, cmd.pos};
  assign set_bit  = (cmd.op == OP_SET_T) ? f_value[0] : cmd.imm;
  assign idx_ok   = set_idx < 32'(OUT_W);
  assign set_word = (shadow & ~(OUT_W'(1) << set_idx)) | (OUT_W'(set_bit) << set_idx);
  assign out_data = is_wr ? f_value[OUT_W-1:0] : set_word;
  assign out_push = is_wr | (is_set & idx_ok);

  assign deq         = ~out_empty & (hold_cnt <= HW'(1));
  assign out_push_ok = out_push & (~out_full | deq);

  io_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (out_push),
    .push_data (out_data),
    .pop       (deq),
    .pop_data  (out_head),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync     <= '0;
      io_out       <= '0;
      last_word    <= '0;
      hold_cnt     <= '0;
      wb_valid     <= 1'b0;
      wb_pos       <= '0;
      wb_value     <= '0;
      in_ovf       <= 1'b0;
      out_ovf      <= 1'b0;
      rd_empty_err <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[1:0], apply_btn};

      if (deq) begin
        io_out   <= out_head;
        hold_cnt <= HW'(HOLD);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (out_push_ok) last_word <= out_data;

      wb_valid <= 1'b0;
      if (cmd_valid) begin
        case (cmd.op)
          OP_RD_IN: if (!in_empty) begin
            wb_valid <= 1'b1;
            wb_pos   <= cmd.pos;
            wb_value <= 32'(in_head);
          end
          OP_RD_BIT: if (!in_empty) begin
            wb_valid <= 1'b1;
            wb_pos   <= cmd.pos;
            wb_value <= {31'b0, bit_val};
          end
          OP_IN_CNT: begin
            wb_valid <= 1'b1;
            wb_pos   <= cmd.pos;
            wb_value <= 32'(in_count);
          end
          default: ;
        endcase
      end

      // Clear first so an error raised in the same cycle still lands.
      if (cmd_valid && cmd.op == OP_CLR) begin
        in_ovf       <= 1'b0;
        out_ovf      <= 1'b0;
        rd_empty_err <= 1'b0;
      end
      if (btn_rise && in_full && !rd_ok)            in_ovf       <= 1'b1;
      if ((out_push && !out_push_ok) || (is_set && !idx_ok)) out_ovf <= 1'b1;
      if (rd_req && in_empty)                       rd_empty_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_dma_engine.sv
// Directed bench for io_dma_engine: command vector table plus multi-cycle queue scenarios.
module tb_io_dma_engine;
  import io_dma_pkg::*;

  localparam int IN_W = 22, OUT_W = 26, DEPTH = 64, CW = 7;

  logic             clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, apply_btn = 1'b0;
  logic [31:0]      cmd_instr = '0, f_value = '0, t_value = '0;
  logic [IN_W-1:0]  io_in = '0;

  logic             cmd_ready, wb_valid, in_ovf, out_ovf, rd_empty_err;
  logic [OUT_W-1:0] io_out;
  logic [7:0]       wb_pos;
  logic [31:0]      wb_value;
  logic [CW-1:0]    in_count, out_count;

  logic             h4_cmd_ready, h4_wb_valid, h4_in_ovf, h4_out_ovf, h4_rd_empty_err;
  logic [OUT_W-1:0] h4_io_out;
  logic [7:0]       h4_wb_pos;
  logic [31:0]      h4_wb_value;
  logic [CW-1:0]    h4_in_count, h4_out_count;

  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  io_dma_engine u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_instr(cmd_instr), .f_value(f_value), .t_value(t_value),
    .apply_btn(apply_btn), .io_in(io_in), .io_out(io_out),
    .wb_valid(wb_valid), .wb_pos(wb_pos), .wb_value(wb_value),
    .in_count(in_count), .out_count(out_count),
    .in_ovf(in_ovf), .out_ovf(out_ovf), .rd_empty_err(rd_empty_err)
  );

  io_dma_engine #(.HOLD(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(h4_cmd_ready),
    .cmd_instr(cmd_instr), .f_value(f_value), .t_value(t_value),
    .apply_btn(apply_btn), .io_in(io_in), .io_out(h4_io_out),
    .wb_valid(h4_wb_valid), .wb_pos(h4_wb_pos), .wb_value(h4_wb_value),
    .in_count(h4_in_count), .out_count(h4_out_count),
    .in_ovf(h4_in_ovf), .out_ovf(h4_out_ovf), .rd_empty_err(h4_rd_empty_err)
  );

  typedef struct {
    logic [31:0] instr, f, t;
    logic        wbv;
    logic [31:0] wbval, out;
    logic        oovf, rde;
  } vec_t;

  vec_t tv[18];

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [7:0] pos,
                                     input logic [7:0] lo);
    return {3'b000, op, pos, 8'h00, lo};
  endfunction

  function automatic vec_t v(input logic [31:0] instr, f, t, input logic wbv,
                             input logic [31:0] wbval, out, input logic oovf, rde);
    vec_t r;
    r.instr = instr; r.f = f; r.t = t; r.wbv = wbv;
    r.wbval = wbval; r.out = out; r.oovf = oovf; r.rde = rde;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0; apply_btn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [IN_W-1:0] val);
    @(negedge clk);
    io_in = val; apply_btn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    apply_btn = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Returns on the falling edge one clock after the command was accepted.
  task automatic issue(input logic [31:0] instr, input logic [31:0] f, input logic [31:0] t);
    @(negedge clk);
    cmd_instr = instr; f_value = f; t_value = t; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev_out;
    logic [31:0] exp_rd[3];

    tv[0]  = v(mk(OP_IN_CNT, 8'h33, 8'd0),  32'h0,        32'h0,   1'b1, 32'd3, 32'h0,       1'b0, 1'b0);
    tv[1]  = v(mk(OP_RD_BIT, 8'h04, 8'd21), 32'h0,        32'h0,   1'b1, 32'd1, 32'h0,       1'b0, 1'b0);
    tv[2]  = v(mk(OP_RD_BIT, 8'h05, 8'd22), 32'h0,        32'h0,   1'b1, 32'd0, 32'h0,       1'b0, 1'b0);
    tv[3]  = v(mk(OP_RD_BIT, 8'h06, 8'd2),  32'h0,        32'h0,   1'b1, 32'd1, 32'h0,       1'b0, 1'b0);
    tv[4]  = v(mk(OP_IN_CNT, 8'h07, 8'd0),  32'h0,        32'h0,   1'b1, 32'd0, 32'h0,       1'b0, 1'b0);
    tv[5]  = v(mk(OP_RD_IN,  8'h08, 8'd0),  32'h0,        32'h0,   1'b0, 32'd0, 32'h0,       1'b0, 1'b1);
    tv[6]  = v(mk(OP_CLR,    8'h00, 8'd0),  32'h0,        32'h0,   1'b0, 32'd0, 32'h0,       1'b0, 1'b0);
    tv[7]  = v(mk(OP_SET_I,  8'd5,  8'd1),  32'h0,        32'h0,   1'b0, 32'd0, 32'h20,      1'b0, 1'b0);
    tv[8]  = v(mk(OP_SET_I,  8'd0,  8'd1),  32'h0,        32'h0,   1'b0, 32'd0, 32'h21,      1'b0, 1'b0);
    tv[9]  = v(mk(OP_WR_OUT, 8'd0,  8'd0),  32'hFFFFFFF5, 32'h0,   1'b0, 32'd0, 32'h3FFFFF5, 1'b0, 1'b0);
    tv[10] = v(mk(OP_SET_T,  8'd0,  8'd0),  32'h0,        32'd0,   1'b0, 32'd0, 32'h3FFFFF4, 1'b0, 1'b0);
    tv[11] = v(mk(OP_SET_T,  8'd0,  8'd0),  32'hFFFFFFFE, 32'd25,  1'b0, 32'd0, 32'h1FFFFF4, 1'b0, 1'b0);
    tv[12] = v(mk(OP_SET_I,  8'd26, 8'd1),  32'h0,        32'h0,   1'b0, 32'd0, 32'h1FFFFF4, 1'b1, 1'b0);
    tv[13] = v(mk(5'b00000,  8'd3,  8'd1),  32'h12345678, 32'd2,   1'b0, 32'd0, 32'h1FFFFF4, 1'b1, 1'b0);
    tv[14] = v(mk(OP_SET_T,  8'd0,  8'd0),  32'h1,        32'd100, 1'b0, 32'd0, 32'h1FFFFF4, 1'b1, 1'b0);
    tv[15] = v(mk(OP_CLR,    8'd0,  8'd0),  32'h0,        32'h0,   1'b0, 32'd0, 32'h1FFFFF4, 1'b0, 1'b0);
    tv[16] = v(mk(OP_SET_T,  8'd0,  8'd0),  32'h1,        32'd3,   1'b0, 32'd0, 32'h1FFFFFC, 1'b0, 1'b0);
    tv[17] = v(mk(5'b11111,  8'd9,  8'd1),  32'hFFFFFFFF, 32'd4,   1'b0, 32'd0, 32'h1FFFFFC, 1'b0, 1'b0);

    // Reset state
    do_reset();
    chk("rst io_out",    32'(io_out), 32'h0);
    chk("rst wb_valid",  32'(wb_valid), 32'h0);
    chk("rst wb_value",  wb_value, 32'h0);
    chk("rst in_count",  32'(in_count), 32'h0);
    chk("rst out_count", 32'(out_count), 32'h0);
    chk("rst flags",     32'({in_ovf, out_ovf, rd_empty_err}), 32'h0);
    chk("cmd_ready",     32'(cmd_ready), 32'h1);

    // Three presses then three back-to-back reads, in order
    exp_rd[0] = 32'h15; exp_rd[1] = 32'h2A; exp_rd[2] = 32'h3F;
    press(22'h15); press(22'h2A); press(22'h3F);
    @(negedge clk);
    chk("seq in_count", 32'(in_count), 32'd3);
    cmd_instr = mk(OP_RD_IN, 8'h07, 8'd0); cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("seq%0d wb_valid", i), 32'(wb_valid), 32'h1);
      chk($sformatf("seq%0d wb_value", i), wb_value, exp_rd[i]);
      chk($sformatf("seq%0d wb_pos", i),   32'(wb_pos), 32'h07);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("seq wb pulse", 32'(wb_valid), 32'h0);

    // Command table
    do_reset();
    press(22'h3FFFFF); press(22'h3FFFFF); press(22'h2A5);
    prev_out = 32'h0;
    for (int i = 0; i < 18; i++) begin
      issue(tv[i].instr, tv[i].f, tv[i].t);
      chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(tv[i].wbv));
      if (tv[i].wbv) begin
        chk($sformatf("v%0d wb_value", i), wb_value, tv[i].wbval);
        chk($sformatf("v%0d wb_pos", i),   32'(wb_pos), 32'(tv[i].instr[23:16]));
      end
      chk($sformatf("v%0d io_out early", i), 32'(io_out), prev_out);
      chk($sformatf("v%0d out_ovf", i),      32'(out_ovf), 32'(tv[i].oovf));
      chk($sformatf("v%0d rd_empty_err", i), 32'(rd_empty_err), 32'(tv[i].rde));
      @(negedge clk);
      chk($sformatf("v%0d io_out", i),    32'(io_out), tv[i].out);
      chk($sformatf("v%0d wb idle", i),   32'(wb_valid), 32'h0);
      prev_out = tv[i].out;
    end

    // Fill input queue, overflow, clear
    do_reset();
    for (int i = 0; i < DEPTH; i++) press(22'(i + 1));
    @(negedge clk);
    chk("fill in_count", 32'(in_count), 32'd64);
    chk("fill in_ovf",   32'(in_ovf), 32'h0);
    press(22'h3AA);
    @(negedge clk);
    chk("ovf in_count", 32'(in_count), 32'd64);
    chk("ovf in_ovf",   32'(in_ovf), 32'h1);
    issue(mk(OP_CLR, 8'd0, 8'd0), 32'h0, 32'h0);
    chk("clr in_ovf", 32'(in_ovf), 32'h0);

    // Button edge coinciding with a pop on a full queue
    @(negedge clk);
    io_in = 22'h77; apply_btn = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    cmd_instr = mk(OP_RD_IN, 8'h01, 8'd0); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("full pp wb_valid", 32'(wb_valid), 32'h1);
    chk("full pp wb_value", wb_value, 32'h1);
    chk("full pp in_count", 32'(in_count), 32'd64);
    chk("full pp in_ovf",   32'(in_ovf), 32'h0);
    apply_btn = 1'b0;
    repeat (3) @(posedge clk);

    // Drain: entries 2..64 then the coincident push, across the pointer wrap
    @(negedge clk);
    cmd_instr = mk(OP_RD_IN, 8'h02, 8'd0); cmd_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d", k), wb_value, (k < DEPTH - 1) ? 32'(k + 2) : 32'h77);
    end
    cmd_valid = 1'b0;
    chk("drain in_count", 32'(in_count), 32'd0);
    chk("drain rd_err",   32'(rd_empty_err), 32'h0);

    // Reset mid-operation discards queued data
    press(22'h11); press(22'h22);
    @(negedge clk);
    chk("mid in_count", 32'(in_count), 32'd2);
    do_reset();
    chk("mid rst in_count", 32'(in_count), 32'd0);
    press(22'h5A);
    issue(mk(OP_RD_IN, 8'h00, 8'd0), 32'h0, 32'h0);
    chk("mid first entry", wb_value, 32'h5A);

    // HOLD=4 pacing on the second instance
    do_reset();
    @(negedge clk);
    cmd_instr = mk(OP_WR_OUT, 8'd0, 8'd0); f_value = 32'h1; cmd_valid = 1'b1;
    @(negedge clk);
    chk("h4 io_out e1", 32'(h4_io_out), 32'h0);
    f_value = 32'h2;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("h4 io_out c0", 32'(h4_io_out), 32'h1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("h4 io_out c%0d", k), 32'(h4_io_out), 32'h1);
    end
    @(negedge clk);
    chk("h4 io_out next", 32'(h4_io_out), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
